fault_alarm_handler: RTL and testbench
======================================

# fault_alarm_handler

Response controller directly downstream of the fault-attack invariant monitor in the Ariane integration. It consumes the monitor's combinational `alarm` and per-invariant failure vector. It records sticky causes and a saturating event count, and requests a pipeline flush. After the flush it reports to software via interrupt, and escalates to permanent lockdown on repeated alarms or an unacknowledged flush.

## Interface
- `NumInvariants`, 11, width of cause vector (one bit per monitor invariant)
- `AlarmThreshold`, 3, alarm events at which lockdown is entered; legal range 1..2^CntWidth-1
- `CntWidth`, 8, width of event counter
- `FlushTimeout`, 64, cycles in FLUSH without ack before escalation; ≥1
- `clk_i`  in  1  core clock
- `rst_ni`  in  1  reset, asynchronous, active-low
- `alarm_i`  in  1  monitor alarm (level)
- `cause_i`  in  NumInvariants  bit i = invariant i enabled and violated, same cycle as `alarm_i`
- `flush_req_o`  out  1  flush request to controller (level)
- `flush_ack_i`  in  1  flush completed (single-cycle pulse)
- `clear_i`  in  1  software clear pulse (CSR write)
- `irq_o`  out  1  level interrupt to CLIC/PLIC
- `lockdown_o`  out  1  permanent lockdown; sticky until reset
- `cause_q_o`  out  NumInvariants  sticky OR of causes since last clear
- `event_cnt_o`  out  CntWidth  saturating count of alarm events since reset
- `state_o`  out  2  current FSM state (debug)

## Operation
- Event = rising edge of `alarm_i`: `alarm_i`=1 while registered `alarm_q`=0. A held alarm counts once.
- On event, in any state except LOCK:
  - `event_cnt` += 1, saturating at 2^CntWidth-1.
  - `cause_q` |= `cause_i`.
- Threshold check uses the post-increment count. Count ≥ AlarmThreshold → LOCK from any state.
- States: IDLE=0, FLUSH=1, REPORT=2, LOCK=3.
- IDLE: event below threshold → FLUSH. Outputs low except `cause_q_o`/`event_cnt_o`.
- FLUSH:
  - `flush_req_o`=1; timer increments each cycle.
  - `flush_ack_i` → REPORT.
  - No ack with timer == FlushTimeout-1 → LOCK. Ack and timeout in the same cycle: ack wins.
  - A further event updates count/cause and stays in FLUSH; the timer is not restarted.
- REPORT:
  - `irq_o`=1.
  - `clear_i` → IDLE and zero `cause_q`; `event_cnt` is not cleared.
  - Event → FLUSH, irq drops, timer restarts at 0.
  - Event and `clear_i` in the same cycle: `cause_q` ← `cause_i` (clear then OR), next state FLUSH.
- LOCK:
  - `lockdown_o`=1, `flush_req_o`=1, `irq_o`=1.
  - `clear_i`, `flush_ack_i` and events are ignored; count and cause are frozen.
  - Exit only by reset.
- `clear_i` outside REPORT is ignored. `flush_ack_i` outside FLUSH is ignored.

## Timing
- All outputs are registered (Moore from state/flops); no combinational input→output path.
- Reset values: state IDLE; `alarm_q`, timer, `event_cnt_o`, `cause_q_o`, `flush_req_o`, `irq_o`, `lockdown_o` all 0; `state_o`=0.
- Event sampled in cycle N → in cycle N+1 `flush_req_o`=1 (or `lockdown_o`=1), with `event_cnt_o`/`cause_q_o` updated.
- Ack sampled in cycle M → in cycle M+1 `flush_req_o`=0 and `irq_o`=1.
- Unacknowledged flush: `flush_req_o` is high in FLUSH for exactly FlushTimeout cycles, then `lockdown_o`=1 on the next cycle.
- `clear_i` in cycle K → in cycle K+1 `irq_o`=0 and `cause_q_o`=0.
- Reset asserted mid-operation, including in LOCK, returns all state to reset values immediately (async).
- `alarm_i` high at reset release: `alarm_q`=0, so it counts as an event in the first cycle (fail-secure).

## Test plan
- Single alarm: `alarm_i` 1 cycle, `cause_i`=0x004; ack 5 cycles later → `flush_req_o` high 5 cycles; `event_cnt_o`=1, `cause_q_o`=0x004; `irq_o`=1; `clear_i` → IDLE, `cause_q_o`=0, `event_cnt_o` stays 1.
- Held alarm: `alarm_i` high 20 cycles → `event_cnt_o`=1, single FLUSH entry.
- Threshold: three separated events with ack/clear between → third event sets `lockdown_o`=1 next cycle; `clear_i`/`flush_ack_i` then ignored; only `rst_ni` low clears it.
- Timeout: event, no ack, FlushTimeout=64 → `flush_req_o` high 64 cycles, `lockdown_o`=1 on cycle 65.
- Collisions: ack coinciding with the timeout cycle → REPORT, not LOCK. Event plus clear in REPORT with `cause_i`=0x100 → `cause_q_o`=0x100, state FLUSH.
- Saturation: CntWidth=2, AlarmThreshold=3 → count 3 enters LOCK. With AlarmThreshold=3, CntWidth=8, reset in LOCK → all outputs 0; `alarm_i` high at reset release → count 1.

Source files
------------

// File: rtl/fault_alarm_handler.sv
// Fault-attack alarm response: sticky cause capture, saturating event count,
// flush request, software interrupt and escalation to permanent lockdown.
// All outputs registered; one-cycle latency from any input to any output.
module fault_alarm_handler #(
  parameter int NumInvariants  = 11,
  parameter int AlarmThreshold = 3,
  parameter int CntWidth       = 8,
  parameter int FlushTimeout   = 64
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     alarm_i,
  input  logic [NumInvariants-1:0] cause_i,
  output logic                     flush_req_o,
  input  logic                     flush_ack_i,
  input  logic                     clear_i,
  output logic                     irq_o,
  output logic                     lockdown_o,
  output logic [NumInvariants-1:0] cause_q_o,
  output logic [CntWidth-1:0]      event_cnt_o,
  output logic [1:0]               state_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    FLUSH  = 2'd1,
    REPORT = 2'd2,
    LOCK   = 2'd3
  } state_e;

  // One extra bit so FlushTimeout == 1 still yields a legal width.
  localparam int TimerWidth = $clog2(FlushTimeout + 1);
  localparam logic [TimerWidth-1:0] TimerLast = TimerWidth'(FlushTimeout - 1);
  localparam logic [CntWidth-1:0]   CntMax    = {CntWidth{1'b1}};
  localparam logic [CntWidth-1:0]   Thresh    = CntWidth'(AlarmThreshold);

  state_e                   state_q, state_d;
  logic                     alarm_q;
  logic [TimerWidth-1:0]    timer_q, timer_d;
  logic [CntWidth-1:0]      cnt_q, cnt_d, cnt_inc;
  logic [NumInvariants-1:0] cause_q, cause_d;
  logic                     flush_q, irq_q, lock_q;
  logic                     event_w, over_thr;

  // A held alarm is one event: only the rising edge counts.
  assign event_w  = alarm_i & ~alarm_q;
  assign cnt_inc  = (cnt_q == CntMax) ? cnt_q : cnt_q + CntWidth'(1);
  assign over_thr = (cnt_inc >= Thresh);

  // Next-state, timer, counter and cause computation.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    cnt_d   = cnt_q;
    cause_d = cause_q;

    // LOCK freezes the forensic record.
    if (event_w && (state_q != LOCK)) begin
      cnt_d   = cnt_inc;
      cause_d = cause_q | cause_i;
    end

    case (state_q)
      IDLE: begin
        if (event_w) begin
          state_d = over_thr ? LOCK : FLUSH;
          timer_d = '0;
        end
      end
      FLUSH: begin
        // Timer keeps running across further events; only REPORT restarts it.
        timer_d = timer_q + TimerWidth'(1);
        if (event_w && over_thr) begin
          state_d = LOCK;
        end else if (flush_ack_i) begin
          state_d = REPORT;
        end else if (timer_q == TimerLast) begin
          state_d = LOCK;
        end
      end
      REPORT: begin
        if (event_w) begin
          // Clear then OR when software clears in the same cycle.
          if (clear_i) begin
            cause_d = cause_i;
          end
          state_d = over_thr ? LOCK : FLUSH;
          timer_d = '0;
        end else if (clear_i) begin
          state_d = IDLE;
          cause_d = '0;
        end
      end
      LOCK: begin
        state_d = LOCK;
      end
      default: begin
        // Unreachable encoding: fail secure.
        state_d = LOCK;
      end
    endcase
  end

  // State register with Moore outputs decoded from the next state.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      alarm_q <= 1'b0;
      timer_q <= '0;
      cnt_q   <= '0;
      cause_q <= '0;
      flush_q <= 1'b0;
      irq_q   <= 1'b0;
      lock_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      alarm_q <= alarm_i;
      timer_q <= timer_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
      flush_q <= (state_d == FLUSH) || (state_d == LOCK);
      irq_q   <= (state_d == REPORT) || (state_d == LOCK);
      lock_q  <= (state_d == LOCK);
    end
  end

  assign flush_req_o = flush_q;
  assign irq_o       = irq_q;
  assign lockdown_o  = lock_q;
  assign cause_q_o   = cause_q;
  assign event_cnt_o = cnt_q;
  assign state_o     = state_q;

endmodule

// File: tb/tb_fault_alarm_handler.sv
// Directed bench for fault_alarm_handler: flush/report/clear flow, held alarm,
// threshold lockdown, timeout, collisions, saturation and async reset.
// A second instance with CntWidth=2 shares all inputs.
module tb_fault_alarm_handler;
  localparam int NI = 11;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          alarm, ack, clr;
  logic [NI-1:0] cause;

  logic          flush, irq, lock;
  logic [NI-1:0] cause_q;
  logic [7:0]    cnt;
  logic [1:0]    st;

  logic          flush2, irq2, lock2;
  logic [NI-1:0] cause_q2;
  logic [1:0]    cnt2;
  logic [1:0]    st2;

  int total = 0;
  int bad   = 0;

  fault_alarm_handler #(.NumInvariants(NI), .AlarmThreshold(3), .CntWidth(8), .FlushTimeout(64)) dut (
    .clk_i(clk), .rst_ni(rst_n), .alarm_i(alarm), .cause_i(cause),
    .flush_req_o(flush), .flush_ack_i(ack), .clear_i(clr), .irq_o(irq),
    .lockdown_o(lock), .cause_q_o(cause_q), .event_cnt_o(cnt), .state_o(st)
  );

  fault_alarm_handler #(.NumInvariants(NI), .AlarmThreshold(3), .CntWidth(2), .FlushTimeout(64)) dut2 (
    .clk_i(clk), .rst_ni(rst_n), .alarm_i(alarm), .cause_i(cause),
    .flush_req_o(flush2), .flush_ack_i(ack), .clear_i(clr), .irq_o(irq2),
    .lockdown_o(lock2), .cause_q_o(cause_q2), .event_cnt_o(cnt2), .state_o(st2)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_alarm(input logic [NI-1:0] c);
    alarm = 1'b1;
    cause = c;
    tick();
    alarm = 1'b0;
    cause = '0;
  endtask

  task automatic ack_pulse();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic clr_pulse();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  initial begin : stim
    int n;
    int guard;
    rst_n = 1'b1;
    alarm = 1'b0;
    ack   = 1'b0;
    clr   = 1'b0;
    cause = '0;
    #2;

    // Reset state
    rst_n = 1'b0;
    tick();
    chk("rst_flush", 32'(flush), 32'd0);
    chk("rst_irq",   32'(irq),   32'd0);
    chk("rst_lock",  32'(lock),  32'd0);
    chk("rst_cause", 32'(cause_q), 32'd0);
    chk("rst_cnt",   32'(cnt),   32'd0);
    chk("rst_state", 32'(st),    32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_state", 32'(st), 32'd0);

    // Single alarm, ack after 5 flush cycles, then clear
    pulse_alarm(11'h004);
    chk("s_flush0", 32'(flush), 32'd1);
    chk("s_cnt",    32'(cnt),   32'd1);
    chk("s_cause",  32'(cause_q), 32'h004);
    chk("s_state",  32'(st),    32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("s_flush_hold", 32'(flush), 32'd1);
    end
    ack_pulse();
    chk("s_flush_off", 32'(flush), 32'd0);
    chk("s_irq",       32'(irq),   32'd1);
    chk("s_report",    32'(st),    32'd2);
    tick();
    clr_pulse();
    chk("s_clr_irq",   32'(irq),   32'd0);
    chk("s_clr_cause", 32'(cause_q), 32'd0);
    chk("s_clr_cnt",   32'(cnt),   32'd1);
    chk("s_clr_state", 32'(st),    32'd0);

    // Threshold: three separated events -> lockdown
    do_reset();
    pulse_alarm(11'h001);
    ack_pulse();
    clr_pulse();
    pulse_alarm(11'h002);
    chk("t_cnt2",  32'(cnt), 32'd2);
    chk("t_st2",   32'(st),  32'd1);
    ack_pulse();
    clr_pulse();
    pulse_alarm(11'h400);
    chk("t_lock",   32'(lock), 32'd1);
    chk("t_lstate", 32'(st),   32'd3);
    chk("t_cnt3",   32'(cnt),  32'd3);
    chk("t_cause",  32'(cause_q), 32'h400);
    chk("t_lflush", 32'(flush), 32'd1);
    chk("t_lirq",   32'(irq),   32'd1);
    chk("sat_cnt",  32'(cnt2),  32'd3);
    chk("sat_lock", 32'(lock2), 32'd1);
    tick();
    clr_pulse();
    ack_pulse();
    tick();
    pulse_alarm(11'h7ff);
    tick();
    chk("t_frz_lock",  32'(lock),    32'd1);
    chk("t_frz_state", 32'(st),      32'd3);
    chk("t_frz_cnt",   32'(cnt),     32'd3);
    chk("t_frz_cause", 32'(cause_q), 32'h400);

    // Async reset while in LOCK, alarm held across reset release
    alarm = 1'b1;
    cause = 11'h020;
    rst_n = 1'b0;
    #1;
    chk("ar_lock",  32'(lock),  32'd0);
    chk("ar_flush", 32'(flush), 32'd0);
    chk("ar_irq",   32'(irq),   32'd0);
    chk("ar_cnt",   32'(cnt),   32'd0);
    chk("ar_cause", 32'(cause_q), 32'd0);
    chk("ar_state", 32'(st),    32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("rel_cnt",   32'(cnt),   32'd1);
    chk("rel_flush", 32'(flush), 32'd1);
    chk("rel_cause", 32'(cause_q), 32'h020);
    // Held for 20 cycles total: still one event
    for (int i = 0; i < 19; i++) tick();
    alarm = 1'b0;
    cause = '0;
    tick();
    chk("held_cnt",   32'(cnt), 32'd1);
    chk("held_state", 32'(st),  32'd1);
    ack_pulse();
    chk("held_report", 32'(st), 32'd2);

    // Timeout: flush high exactly 64 cycles, then lockdown
    do_reset();
    pulse_alarm(11'h008);
    n = 0;
    guard = 0;
    while (!lock && guard < 200) begin
      if (flush) n++;
      tick();
      guard++;
    end
    chk("to_lock",  32'(lock), 32'd1);
    chk("to_cycles", 32'(n),   32'd64);
    chk("to_state", 32'(st),   32'd3);

    // Ack in the timeout cycle wins
    do_reset();
    pulse_alarm(11'h010);
    for (int i = 0; i < 63; i++) tick();
    chk("col_pre_lock", 32'(lock), 32'd0);
    ack_pulse();
    chk("col_state", 32'(st),   32'd2);
    chk("col_lock",  32'(lock), 32'd0);
    chk("col_irq",   32'(irq),  32'd1);

    // Event plus clear in REPORT
    alarm = 1'b1;
    cause = 11'h100;
    clr   = 1'b1;
    tick();
    alarm = 1'b0;
    cause = '0;
    clr   = 1'b0;
    chk("ec_cause", 32'(cause_q), 32'h100);
    chk("ec_state", 32'(st),    32'd1);
    chk("ec_irq",   32'(irq),   32'd0);
    chk("ec_flush", 32'(flush), 32'd1);
    chk("ec_cnt",   32'(cnt),   32'd2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
